filter_udiv_29ns_22ns_8_seq: RTL
================================

Name: filter_udiv_29ns_22ns_8_seq

Overview:
Sequential unsigned divider for the filter datapath, the inverse of the 8x22->29 product stage. Takes a 29-bit product and its 22-bit coefficient and recovers the 8-bit sample plus a remainder. Uses a restoring radix-2 algorithm, one quotient bit per clock. Input and output are valid/ready handshakes.

Parameters:
DIVIDEND_W, 29, dividend width
DIVISOR_W, 22, divisor width
QUO_W, 8, quotient width; constraint DIVIDEND_W <= DIVISOR_W + QUO_W (elaboration error otherwise)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  dividend/divisor valid
in_ready  out  1  block can accept an operand pair
dividend  in  DIVIDEND_W  unsigned dividend
divisor  in  DIVISOR_W  unsigned divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
quotient  out  QUO_W  unsigned quotient (saturated)
remainder  out  DIVISOR_W  unsigned remainder
ovf  out  1  true quotient > 2^QUO_W-1
dbz  out  1  divisor was zero

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; quotient, remainder, ovf, dbz, counter and working registers all 0.
- FSM IDLE -> CALC -> DONE -> IDLE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, in_valid=1: operands accepted on that edge.
  - divisor==0: go to DONE; quotient=all ones, remainder=0, dbz=1, ovf=0.
  - else if dividend >= (divisor << QUO_W), compared at DIVIDEND_W+1 bits: go to DONE; quotient=all ones, remainder=0, ovf=1, dbz=0.
  - else: go to CALC with R = dividend[DIVIDEND_W-1:QUO_W] zero-extended to DIVISOR_W, Q = dividend[QUO_W-1:0], cnt = QUO_W-1, ovf=dbz=0.
- CALC, each cycle:
  - T = {R, Q[MSB]} (DIVISOR_W+1 bits).
  - If T >= divisor: R = T - divisor, bit = 1; else R = T[DIVISOR_W-1:0], bit = 0.
  - Q = {Q[QUO_W-2:0], bit}.
  - When cnt==0: go to DONE, quotient = Q-next, remainder = R-next. Otherwise cnt decrements.
- Latency, counted from the accept cycle = 0:
  - normal: out_valid high in cycle QUO_W+1 (9).
  - exception (dbz/ovf): out_valid high in cycle 1.
- DONE: quotient, remainder, ovf and dbz stay stable while out_valid=1 and out_ready=0. On out_valid and out_ready both 1, go to IDLE; outputs keep their values (not cleared).
- No input acceptance in CALC or DONE. Minimum issue interval is QUO_W+2 cycles with out_ready tied high.
- in_valid in IDLE must not depend on in_ready. Operands are sampled only at the accept edge; later operand changes are ignored.
- ap_rst_n low at any time, including mid-CALC: immediate return to reset values; the in-flight result is discarded and out_valid is never asserted for it.
- Invariant: R < divisor throughout CALC. Guaranteed by the overflow pre-check, so quotient never wraps.

Decomposition:
- Shared package filter_div_pkg:
  - width constants DIVIDEND_W, DIVISOR_W, QUO_W;
  - state enum IDLE/CALC/DONE (2-bit encoding);
  - localparam CNT_W = $clog2(QUO_W).
- One sub-module: filter_udiv_step. Combinational single restoring step: inputs R, shift-in bit, divisor; outputs R-next, quotient bit. Instantiated once and reused every CALC cycle.

Test Plan:
- dividend=200000123, divisor=1000000, out_ready=1 -> quotient=200, remainder=123, ovf=0, dbz=0; out_valid rises exactly 9 cycles after accept.
- dividend=536870911, divisor=2097152 (boundary, no overflow) -> quotient=255, remainder=2097151, ovf=0. Then divisor=2097151, same dividend -> quotient=255, remainder=0, ovf=1, out_valid at cycle 1.
- dividend=12345, divisor=0 -> dbz=1, quotient=255, remainder=0, out_valid at cycle 1. Then dividend=0, divisor=7 -> quotient=0, remainder=0.
- Normal divide with out_ready held low 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; in_ready=1 the cycle after the out handshake. A second in_valid pulse during CALC is ignored.
- ap_rst_n pulsed low in the 4th CALC cycle -> in_ready=1, out_valid=0, all outputs 0 immediately. A subsequent 255*4000+7 / 4000 completes as quotient=255, remainder=7.
- Random regression of 10k pairs with random out_ready backpressure -> quotient*divisor+remainder == dividend whenever ovf=dbz=0; ovf set exactly when dividend/divisor > 255.

Source files
------------

// File: rtl/filter_div_pkg.sv
// ============================================================================
// Module  : filter_div_pkg
// Brief   : Shared widths and FSM encoding for the filter sequential divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package filter_div_pkg;

  localparam int DIVIDEND_W = 29;
  localparam int DIVISOR_W  = 22;
  localparam int QUO_W      = 8;
  localparam int CNT_W      = $clog2(QUO_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/filter_udiv_step.sv
// ============================================================================
// Module  : filter_udiv_step
// Brief   : One combinational restoring-division step (shift in, trial subtract).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_udiv_step #(
  parameter int DIVISOR_W = 22
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 shift_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] trial;

  always_comb begin
    trial = {rem_in, shift_in};
    q_bit = (trial >= {1'b0, divisor});
    // rem_in < divisor keeps the difference below 2^DIVISOR_W, so a narrow subtract suffices
    rem_out = q_bit ? (trial[DIVISOR_W-1:0] - divisor) : trial[DIVISOR_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/filter_udiv_29ns_22ns_8_seq.sv
// ============================================================================
// Module  : filter_udiv_29ns_22ns_8_seq
// Brief   : Radix-2 restoring unsigned divider, one quotient bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_udiv_29ns_22ns_8_seq #(
  parameter int DIVIDEND_W = filter_div_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = filter_div_pkg::DIVISOR_W,
  parameter int QUO_W      = filter_div_pkg::QUO_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUO_W-1:0]      quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dbz
);

  import filter_div_pkg::*;

  localparam int CNT_BITS = (QUO_W > 1) ? $clog2(QUO_W) : 1;
  localparam int CMP_W    = DIVISOR_W + QUO_W;

  if (DIVIDEND_W > DIVISOR_W + QUO_W) begin : g_width_check
    $error("DIVIDEND_W must not exceed DIVISOR_W + QUO_W");
  end

  state_e                state_r;
  state_e                state_nxt;
  logic [DIVISOR_W-1:0]  rem_r;
  logic [QUO_W-1:0]      quo_r;
  logic [CNT_BITS-1:0]   cnt_r;
  logic [DIVISOR_W-1:0]  dvs_r;

  logic                  accept;
  logic                  is_dbz;
  logic                  is_ovf;
  logic [CMP_W-1:0]      dvd_ext;
  logic [CMP_W-1:0]      dvs_shift;
  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  q_bit;
  logic [QUO_W-1:0]      quo_nxt;

  assign accept    = (state_r == IDLE) && in_valid;
  assign dvd_ext   = CMP_W'(dividend);
  assign dvs_shift = {divisor, {QUO_W{1'b0}}};
  assign is_dbz    = (divisor == '0);
  // Any quotient that would not fit QUO_W bits is caught here, so CALC never wraps
  assign is_ovf    = (dvd_ext >= dvs_shift);

  filter_udiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in   (rem_r),
    .shift_in (quo_r[QUO_W-1]),
    .divisor  (dvs_r),
    .rem_out  (rem_nxt),
    .q_bit    (q_bit)
  );

  assign quo_nxt = {quo_r[QUO_W-2:0], q_bit};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (is_dbz || is_ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_r == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rem_r     <= '0;
      quo_r     <= '0;
      cnt_r     <= '0;
      dvs_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else if (accept) begin
      dvs_r <= divisor;
      if (is_dbz) begin
        quotient  <= '1;
        remainder <= '0;
        dbz       <= 1'b1;
        ovf       <= 1'b0;
      end else if (is_ovf) begin
        quotient  <= '1;
        remainder <= '0;
        dbz       <= 1'b0;
        ovf       <= 1'b1;
      end else begin
        rem_r <= DIVISOR_W'(dividend[DIVIDEND_W-1:QUO_W]);
        quo_r <= dividend[QUO_W-1:0];
        cnt_r <= CNT_BITS'(QUO_W - 1);
        dbz   <= 1'b0;
        ovf   <= 1'b0;
      end
    end else if (state_r == CALC) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      if (cnt_r == '0) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
      end else begin
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
